// File: rtl/fclk_div_bank.sv
// Bank of independent integer clock dividers, ratio DIV+2, with glitch-free stop and shared phase realign.
// Outputs registered from next-state counter: O/CE/ACTIVE change together one edge after inputs.
module fclk_div_bank #(
    parameter int N_CH      = 2,
    parameter int DIV_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_CH-1:0]           EN,
    input  logic [N_CH*DIV_WIDTH-1:0] DIV,
    input  logic                      SYNC,
    output logic [N_CH-1:0]           O,
    output logic [N_CH-1:0]           CE,
    output logic [N_CH-1:0]           ACTIVE
);

    localparam int CW = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t        st_q, st_n;
        logic [CW-1:0] cnt_q, cnt_n;
        logic [CW-1:0] ratio_q, ratio_n, ratio_div;
        logic          o_q, ce_q, wrap;

        assign ratio_div = {1'b0, DIV[k*DIV_WIDTH +: DIV_WIDTH]} + CW'(2);
        assign wrap      = (cnt_q == ratio_q - CW'(1));

        always_comb begin
            st_n    = st_q;
            cnt_n   = cnt_q;
            ratio_n = ratio_q;
            case (st_q)
                IDLE: begin
                    if (EN[k]) begin
                        st_n    = RUN;
                        cnt_n   = '0;
                        ratio_n = ratio_div;
                    end
                end
                default: begin
                    st_n = EN[k] ? RUN : STOPPING;
                    if (SYNC) begin
                        cnt_n   = '0;
                        ratio_n = ratio_div;
                    end else if (wrap) begin
                        cnt_n = '0;
                        // A stopping channel only parks once its final period is complete.
                        if (st_q == STOPPING && !EN[k]) begin
                            st_n = IDLE;
                        end else begin
                            ratio_n = ratio_div;
                        end
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                st_q    <= IDLE;
                cnt_q   <= '0;
                ratio_q <= '0;
                o_q     <= 1'b0;
                ce_q    <= 1'b0;
            end else begin
                st_q    <= st_n;
                cnt_q   <= cnt_n;
                ratio_q <= ratio_n;
                // High phase is ceil(R/2) so odd ratios get the extra cycle high.
                o_q     <= (st_n != IDLE) && (cnt_n < ((ratio_n + CW'(1)) >> 1));
                ce_q    <= (st_n != IDLE) && (cnt_n == ratio_n - CW'(1));
            end
        end

        assign O[k]      = o_q;
        assign CE[k]     = ce_q;
        assign ACTIVE[k] = (st_q != IDLE);
    end

endmodule

// File: tb/tb_fclk_div_bank.sv
// Scoreboard bench for fclk_div_bank: expected {ACTIVE,CE,O} pushed per edge, popped and compared after it.
module tb_fclk_div_bank;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SYNC;
    logic [1:0] EN;
    logic [7:0] DIV;
    logic [1:0] O, CE, ACTIVE;

    int         tests = 0;
    int         fails = 0;
    logic [5:0] sb[$];

    always #5 CLK = ~CLK;

    fclk_div_bank #(.N_CH(2), .DIV_WIDTH(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .DIV   (DIV),
        .SYNC  (SYNC),
        .O     (O),
        .CE    (CE),
        .ACTIVE(ACTIVE)
    );

    // Expected {active, ce, o} of one channel given its counter and ratio.
    function automatic logic [2:0] ch_exp(input int cnt, input int r, input bit act);
        ch_exp = {act, act && (cnt == r - 1), act && (cnt < (r + 1) / 2)};
    endfunction

    function automatic logic [5:0] pack2(input logic [2:0] e0, input logic [2:0] e1);
        pack2 = {e1[2], e0[2], e1[1], e0[1], e1[0], e0[0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 2'b00; SYNC = 1'b0; DIV = 8'h00;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        RST = 1'b1; EN = 2'b11; SYNC = 1'b1; DIV = 8'h33;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(6'b0);
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL reset cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
        RST = 1'b0; EN = 2'b00; SYNC = 1'b0;
        sb.push_back(6'b0);
        tick();
        exp = sb.pop_front();
        tests++;
        if ({ACTIVE, CE, O} !== exp) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want %b", {ACTIVE, CE, O}, exp);
        end
    endtask

    task automatic test_div0();
        logic [5:0] exp;
        do_reset();
        DIV = 8'h00; EN = 2'b01;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(pack2(ch_exp(i % 2, 2, 1'b1), 3'b000));
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL div0 cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
    endtask

    task automatic test_div3();
        logic [5:0] exp;
        do_reset();
        DIV = 8'h03; EN = 2'b01;
        for (int i = 0; i < 12; i++) begin
            sb.push_back(pack2(ch_exp(i % 5, 5, 1'b1), 3'b000));
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL div3 cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
    endtask

    task automatic test_div_change();
        logic [5:0] exp;
        do_reset();
        DIV = 8'h03; EN = 2'b01;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) DIV = 8'h06;
            if (i < 5) sb.push_back(pack2(ch_exp(i, 5, 1'b1), 3'b000));
            else       sb.push_back(pack2(ch_exp((i - 5) % 8, 8, 1'b1), 3'b000));
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL div_change cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
    endtask

    task automatic test_stop();
        logic [5:0] exp;
        int         cnt;
        bit         act;
        do_reset();
        DIV = 8'h03; EN = 2'b01;
        for (int i = 0; i < 15; i++) begin
            case (i)
                2:  EN = 2'b00;
                8:  EN = 2'b01;
                10: EN = 2'b00;
                11: EN = 2'b01;
                default: ;
            endcase
            act = 1'b1;
            if (i < 5)       cnt = i;
            else if (i < 8)  begin cnt = 0; act = 1'b0; end
            else             cnt = (i - 8) % 5;
            sb.push_back(pack2(ch_exp(cnt, 5, act), 3'b000));
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL stop cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
    endtask

    task automatic test_sync();
        logic [5:0] exp;
        int         c0 = 0;
        int         c1 = 0;
        do_reset();
        DIV = 8'h42; EN = 2'b01;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) EN = 2'b11;
            SYNC = (i == 1 || i == 6);
            if (i == 0 || SYNC) c0 = 0;
            else                c0 = (c0 == 3) ? 0 : c0 + 1;
            if (i == 3 || (i > 3 && SYNC)) c1 = 0;
            else if (i > 3)                c1 = (c1 == 5) ? 0 : c1 + 1;
            sb.push_back(pack2(ch_exp(c0, 4, 1'b1), (i >= 3) ? ch_exp(c1, 6, 1'b1) : 3'b000));
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL sync cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
        SYNC = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        do_reset();
        DIV = 8'h04; EN = 2'b11;
        for (int i = 0; i < 6; i++) begin
            RST  = (i == 2);
            SYNC = (i == 2);
            case (i)
                0, 3:    sb.push_back(pack2(ch_exp(0, 6, 1'b1), ch_exp(0, 2, 1'b1)));
                1, 4:    sb.push_back(pack2(ch_exp(1, 6, 1'b1), ch_exp(1, 2, 1'b1)));
                2:       sb.push_back(6'b0);
                default: sb.push_back(pack2(ch_exp(2, 6, 1'b1), ch_exp(0, 2, 1'b1)));
            endcase
            tick();
            exp = sb.pop_front();
            tests++;
            if ({ACTIVE, CE, O} !== exp) begin
                fails++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, {ACTIVE, CE, O}, exp);
            end
        end
        RST = 1'b0; SYNC = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = 2'b00; SYNC = 1'b0; DIV = 8'h00;
        test_reset();
        test_div0();
        test_div3();
        test_div_change();
        test_stop();
        test_sync();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
